// File: rtl/inst_queue.sv
// inst_queue: circular instruction FIFO between fetch/decode and dispatch.
// Each entry holds the instruction word, its PC, the predictor's taken bit and the
// predicted target. A commit-side flush empties the queue in one edge.
// Optional feature: define INSTQ_BYPASS_EN to forward an enqueue straight to the
// Deq_* outputs while the queue is empty (zero-cycle latency).
module inst_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Enq_Valid,
  input  logic [31:0]             Enq_Inst,
  input  logic [31:0]             Enq_PC,
  input  logic                    Enq_Prediction,
  input  logic [31:0]             Enq_Target,
  output logic                    Enq_Ready,
  input  logic                    Deq_Ready,
  output logic                    Deq_Valid,
  output logic [31:0]             Deq_Inst,
  output logic [31:0]             Deq_PC,
  output logic                    Deq_Prediction,
  output logic [31:0]             Deq_Target,
  input  logic                    FLUSH_Flag,
  output logic                    FULL_FLAG,
  output logic                    EMPTY_FLAG,
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Entry storage; deliberately not reset, the pointers define what is live.
  logic [31:0] mem_inst [DEPTH];
  logic [31:0] mem_pc   [DEPTH];
  logic        mem_pred [DEPTH];
  logic [31:0] mem_tgt  [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic full, empty;
  logic bypass, bypass_fire;
  logic enq_fire, deq_fire;
  logic do_enq, do_deq;

  assign full       = (count_q == CntW'(DEPTH));
  assign empty      = (count_q == '0);
  assign FULL_FLAG  = full;
  assign EMPTY_FLAG = empty;
  assign Count      = count_q;
  // Enqueue never depends on a same-cycle dequeue freeing a slot.
  assign Enq_Ready  = !full;

`ifdef INSTQ_BYPASS_EN
  // rst gating keeps all Deq_* outputs quiet while reset is held.
  assign bypass = rst && empty && Enq_Valid && !FLUSH_Flag;
`else
  assign bypass = 1'b0;
`endif

  assign Deq_Valid   = !empty || bypass;
  assign enq_fire    = Enq_Valid && !full && !FLUSH_Flag;
  assign deq_fire    = Deq_Valid && Deq_Ready && !FLUSH_Flag;
  // A bypassed instruction consumed in the same cycle never touches storage.
  assign bypass_fire = bypass && Deq_Ready;
  assign do_enq      = enq_fire && !bypass_fire;
  assign do_deq      = deq_fire && !bypass_fire;

  // Head fields: bypassed input, stored head, or zeros when nothing is valid.
  always_comb begin
    Deq_Inst       = '0;
    Deq_PC         = '0;
    Deq_Prediction = 1'b0;
    Deq_Target     = '0;
    if (bypass) begin
      Deq_Inst       = Enq_Inst;
      Deq_PC         = Enq_PC;
      Deq_Prediction = Enq_Prediction;
      Deq_Target     = Enq_Target;
    end else if (!empty) begin
      Deq_Inst       = mem_inst[head_q];
      Deq_PC         = mem_pc[head_q];
      Deq_Prediction = mem_pred[head_q];
      Deq_Target     = mem_tgt[head_q];
    end
  end

  // Pointer and occupancy next state; flush overrides everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (FLUSH_Flag) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) tail_d = tail_q + PtrW'(1);
      if (do_deq) head_d = head_q + PtrW'(1);
      unique case ({do_enq, do_deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write the accepted instruction at the tail slot.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem_inst[tail_q] <= Enq_Inst;
      mem_pc[tail_q]   <= Enq_PC;
      mem_pred[tail_q] <= Enq_Prediction;
      mem_tgt[tail_q]  <= Enq_Target;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue (DEPTH = 16): table vectors plus hand-written
// sequences for fill, wrap-around, flush, reset and (when INSTQ_BYPASS_EN) bypass.
module tb_inst_queue;

  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        Enq_Valid;
  logic [31:0] Enq_Inst;
  logic [31:0] Enq_PC;
  logic        Enq_Prediction;
  logic [31:0] Enq_Target;
  logic        Enq_Ready;
  logic        Deq_Ready;
  logic        Deq_Valid;
  logic [31:0] Deq_Inst;
  logic [31:0] Deq_PC;
  logic        Deq_Prediction;
  logic [31:0] Deq_Target;
  logic        FLUSH_Flag;
  logic        FULL_FLAG;
  logic        EMPTY_FLAG;
  logic [4:0]  Count;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .Enq_Valid      (Enq_Valid),
    .Enq_Inst       (Enq_Inst),
    .Enq_PC         (Enq_PC),
    .Enq_Prediction (Enq_Prediction),
    .Enq_Target     (Enq_Target),
    .Enq_Ready      (Enq_Ready),
    .Deq_Ready      (Deq_Ready),
    .Deq_Valid      (Deq_Valid),
    .Deq_Inst       (Deq_Inst),
    .Deq_PC         (Deq_PC),
    .Deq_Prediction (Deq_Prediction),
    .Deq_Target     (Deq_Target),
    .FLUSH_Flag     (FLUSH_Flag),
    .FULL_FLAG      (FULL_FLAG),
    .EMPTY_FLAG     (EMPTY_FLAG),
    .Count          (Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
  } entry_t;

  typedef struct {
    logic        ev;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
    logic        dr;
    logic        fl;
    int          exp_cnt;
  } vec_t;

  entry_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int n_popped = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    Enq_Valid      = 1'b0;
    Enq_Inst       = '0;
    Enq_PC         = '0;
    Enq_Prediction = 1'b0;
    Enq_Target     = '0;
    Deq_Ready      = 1'b0;
    FLUSH_Flag     = 1'b0;
  endtask

  // One clock cycle: drive, check mid-cycle against the scoreboard, update the model.
  task automatic cycle(input logic ev, input logic [31:0] inst, input logic [31:0] pc,
                       input logic pred, input logic [31:0] tgt, input logic dr,
                       input logic fl);
    entry_t e;
    entry_t exp_e;
    logic   exp_v;
    logic   byp;
    Enq_Valid      = ev;
    Enq_Inst       = inst;
    Enq_PC         = pc;
    Enq_Prediction = pred;
    Enq_Target     = tgt;
    Deq_Ready      = dr;
    FLUSH_Flag     = fl;
    e     = '{inst: inst, pc: pc, pred: pred, tgt: tgt};
    byp   = 1'b0;
`ifdef INSTQ_BYPASS_EN
    byp   = (sb.size() == 0) && ev && !fl;
`endif
    exp_v = (sb.size() != 0) || byp;
    exp_e = '0;
    if (byp) exp_e = e;
    else if (sb.size() != 0) exp_e = sb[0];
    @(negedge clk);
    check("deq_valid", 32'(Deq_Valid), 32'(exp_v));
    check("deq_inst", Deq_Inst, exp_e.inst);
    check("deq_pc", Deq_PC, exp_e.pc);
    check("deq_pred", 32'(Deq_Prediction), 32'(exp_e.pred));
    check("deq_tgt", Deq_Target, exp_e.tgt);
    check("count", 32'(Count), 32'(sb.size()));
    check("full", 32'(FULL_FLAG), 32'(sb.size() == DEPTH));
    check("empty", 32'(EMPTY_FLAG), 32'(sb.size() == 0));
    check("enq_ready", 32'(Enq_Ready), 32'(sb.size() != DEPTH));
    if (fl) begin
      sb.delete();
    end else if (byp && dr) begin
      n_popped++;
    end else begin
      if (exp_v && dr) begin
        void'(sb.pop_front());
        n_popped++;
      end
      if (ev && (sb.size() < DEPTH || (exp_v && dr && sb.size() == DEPTH - 1)))
        ;
      // Full-ness is judged before the dequeue takes effect.
    end
    if (!fl && !(byp && dr) && ev && (exp_v && dr ? sb.size() + 1 : sb.size()) < DEPTH)
      sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[10];
  int   i;
  int   guard;
  int   popped0;
  logic acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'h20010005, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1};
    tbl[1] = '{1'b0, 32'h0,        32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1};
    tbl[2] = '{1'b1, 32'h11111111, 32'h4,  1'b1, 32'h100, 1'b1, 1'b0, 1};
    tbl[3] = '{1'b0, 32'h0,        32'h0,  1'b0, 32'h0,   1'b1, 1'b0, 0};
    tbl[4] = '{1'b0, 32'h0,        32'h0,  1'b0, 32'h0,   1'b1, 1'b0, 0};
    tbl[5] = '{1'b1, 32'h22222222, 32'h8,  1'b0, 32'h0,   1'b0, 1'b1, 0};
    tbl[6] = '{1'b1, 32'hAAAA5555, 32'hC,  1'b1, 32'h200, 1'b0, 1'b0, 1};
    tbl[7] = '{1'b1, 32'h0BADF00D, 32'h10, 1'b0, 32'h300, 1'b0, 1'b0, 2};
    tbl[8] = '{1'b0, 32'h0,        32'h0,  1'b0, 32'h0,   1'b1, 1'b0, 1};
    tbl[9] = '{1'b0, 32'h0,        32'h0,  1'b0, 32'h0,   1'b1, 1'b0, 0};

    idle();
    rst = 1'b0;
    #12;
    // Reset state, asynchronously applied.
    check("rst_count", 32'(Count), 32'd0);
    check("rst_empty", 32'(EMPTY_FLAG), 32'd1);
    check("rst_full", 32'(FULL_FLAG), 32'd0);
    check("rst_deq_valid", 32'(Deq_Valid), 32'd0);
    check("rst_enq_ready", 32'(Enq_Ready), 32'd1);
    check("rst_deq_inst", Deq_Inst, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Table vectors.
    foreach (tbl[k]) begin
      cycle(tbl[k].ev, tbl[k].inst, tbl[k].pc, tbl[k].pred, tbl[k].tgt, tbl[k].dr, tbl[k].fl);
      check($sformatf("tbl%0d_count", k), 32'(Count), 32'(tbl[k].exp_cnt));
    end

    // Fill to full, then a 17th enqueue is refused.
    idle();
    for (int n = 0; n < 16; n++)
      cycle(1'b1, 32'h3000 + n, 32'(n * 4), n[0], 32'h8000 + n, 1'b0, 1'b0);
    check("full_flag", 32'(FULL_FLAG), 32'd1);
    check("full_enq_ready", 32'(Enq_Ready), 32'd0);
    cycle(1'b1, 32'hFEEDFACE, 32'h999, 1'b1, 32'h999, 1'b0, 1'b0);
    check("full_17th_count", 32'(Count), 32'd16);

    // Full with simultaneous dequeue and enqueue: only the dequeue happens.
    cycle(1'b1, 32'hDEADBEEF, 32'h777, 1'b0, 32'h777, 1'b1, 1'b0);
    check("full_deq_enq_count", 32'(Count), 32'd15);
    for (int n = 0; n < 15; n++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("drained_empty", 32'(EMPTY_FLAG), 32'd1);

    // 40 ordered enqueues with random dequeue pressure, crossing the wrap point.
    popped0 = n_popped;
    i = 0;
    guard = 0;
    while (i < 40 && guard < 400) begin
      acc = (sb.size() < DEPTH);
      cycle(1'b1, 32'h1000 + i, 32'(i * 4), i[0], 32'h4000 + i, 1'($urandom_range(0, 1)), 1'b0);
      if (acc) i++;
      guard++;
    end
    while (sb.size() != 0 && guard < 400) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      guard++;
    end
    check("wrap_no_timeout", 32'(guard < 400), 32'd1);
    check("wrap_popped", 32'(n_popped - popped0), 32'd40);

    // Flush with 5 queued plus simultaneous enqueue and dequeue.
    for (int n = 0; n < 5; n++)
      cycle(1'b1, 32'h5000 + n, 32'h500 + n, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h55555555, 32'h5555, 1'b1, 32'h5555, 1'b1, 1'b1);
    idle();
    #1;
    check("flush_count", 32'(Count), 32'd0);
    check("flush_empty", 32'(EMPTY_FLAG), 32'd1);
    check("flush_deq_inst", Deq_Inst, 32'd0);

    // Reset asserted mid-cycle with entries queued.
    for (int n = 0; n < 3; n++)
      cycle(1'b1, 32'h6000 + n, 32'h600 + n, 1'b1, 32'h6, 1'b0, 1'b0);
    idle();
    Enq_Valid = 1'b1;
    Enq_Inst  = 32'h66666666;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_count", 32'(Count), 32'd0);
    check("midrst_empty", 32'(EMPTY_FLAG), 32'd1);
    check("midrst_deq_valid", 32'(Deq_Valid), 32'd0);
    check("midrst_deq_inst", Deq_Inst, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    cycle(1'b1, 32'h77777777, 32'h70, 1'b0, 32'h0, 1'b0, 1'b0);
    check("post_rst_count", 32'(Count), 32'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

`ifdef INSTQ_BYPASS_EN
    // Empty queue, enqueue consumed in the same cycle.
    cycle(1'b1, 32'h00000013, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    check("bypass_count", 32'(Count), 32'd0);
`endif

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
